vectrex_cart_loader: RTL
========================

VECTREX_CART_LOADER -- requirements
Module: vectrex_cart_loader

Interface
REQ-001 Parameter TIMEOUT, default 5000000, post-download delay in clk_sys cycles before the skip-logo reset pulse ends.
REQ-002 Parameter PULSE_LEN, default 1000, length in clk_sys cycles of the skip-logo reset pulse.
REQ-003 Parameter MAX_ADDR_W, default 15, cartridge address width (32 KB window).
REQ-004 clk_sys  in  1  sole clock, all logic rising-edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 ioctl_download  in  1  high while the HPS streams a cartridge image.
REQ-007 ioctl_wr  in  1  one-cycle strobe, byte valid on ioctl_dout/ioctl_addr.
REQ-008 ioctl_addr  in  25  byte address of the strobed byte.
REQ-009 ioctl_dout  in  8  strobed byte.
REQ-010 skip_logo  in  1  OSD option; enables the post-download reset pulse.
REQ-011 cart_wr  out  1  registered write strobe to cartridge RAM.
REQ-012 cart_addr  out  15  registered write address.
REQ-013 cart_data  out  8  registered write data.
REQ-014 cart_mask  out  15  address mirror mask for the loaded image.
REQ-015 overflow  out  1  sticky: a byte at ioctl_addr >= 2^MAX_ADDR_W was dropped.
REQ-016 loaded  out  1  high once a download has completed with at least one byte.
REQ-017 core_reset  out  1  reset request to the console: high during download and during the skip-logo pulse.

Function
REQ-018 FSM states IDLE, LOAD, WAIT, PULSE; reset enters IDLE.
REQ-019 IDLE: a rising edge of ioctl_download -> LOAD; clear cart_mask, overflow, loaded and the byte counter on that same edge.
REQ-020 LOAD: each ioctl_wr with ioctl_addr[24:15]==0 -> cart_wr=1 the next cycle with cart_addr=ioctl_addr[14:0] and cart_data=ioctl_dout (latency 1 cycle).
REQ-021 LOAD: ioctl_wr with ioctl_addr[24:15]!=0 -> no cart_wr; overflow set.
REQ-022 cart_mask after each accepted write = cart_mask OR smallest all-ones value >= cart_addr (e.g. addr 0x1234 -> 0x1FFF); the mask never shrinks during a load.
REQ-023 A 16-bit saturating byte counter counts accepted writes.
REQ-024 LOAD: a falling edge of ioctl_download -> WAIT if skip_logo=1 and counter!=0, else IDLE; loaded = (counter!=0).
REQ-025 WAIT: a down-counter loads TIMEOUT-PULSE_LEN and decrements each cycle; at 0 -> PULSE.
REQ-026 PULSE: a counter loads PULSE_LEN and decrements; at 0 -> IDLE.
REQ-027 core_reset = ioctl_download OR (state==PULSE), registered; it is low in WAIT.
REQ-028 A rising edge of ioctl_download in WAIT or PULSE aborts the sequence -> LOAD and applies the clears of REQ-019.
REQ-029 cart_wr is asserted only in LOAD; ioctl_wr outside ioctl_download is ignored.
REQ-030 skip_logo is sampled only at the LOAD exit; later changes do not affect WAIT/PULSE.
REQ-031 If TIMEOUT <= PULSE_LEN, WAIT lasts 1 cycle.

Reset
REQ-032 reset (synchronous) -> state IDLE; cart_wr, cart_addr, cart_data, cart_mask, overflow, loaded, core_reset, all counters = 0 on the next edge.
REQ-033 reset mid-LOAD: the next ioctl_download rising edge is required to re-enter LOAD; an ongoing high download is not resumed.

Structure
REQ-034 A shared package vectrex_pkg holds the state enum and the constants CART_AW=15 and CART_SIZE=32768.
REQ-035 One sub-module, vectrex_mask_gen, is combinational: address -> smallest covering all-ones mask.
REQ-036 Downloaded bytes are not buffered; write-through only.

Verification
REQ-037 Download 8192 sequential bytes 0x0000-0x1FFF, skip_logo=0 -> 8192 cart_wr pulses, each 1 cycle after ioctl_wr; cart_mask=0x1FFF; loaded=1; core_reset falls 1 cycle after download falls.
REQ-038 Download 4096 bytes, skip_logo=1, TIMEOUT=50, PULSE_LEN=10 -> core_reset low 40 cycles after download, then high exactly 10 cycles, then low; state returns to IDLE.
REQ-039 Write at ioctl_addr 0x8000 during download -> no cart_wr, overflow=1 until the next download start.
REQ-040 Restart the download during PULSE -> PULSE aborted, core_reset stays high, cart_mask cleared, new load proceeds.
REQ-041 Assert reset for 1 cycle mid-LOAD after 100 bytes -> all outputs 0 next cycle; the remaining ioctl_wr strobes are ignored until a new ioctl_download rising edge.
REQ-042 Zero-byte download with skip_logo=1 -> loaded=0, no WAIT/PULSE, core_reset follows ioctl_download only.

Source files
------------

// File: rtl/vectrex_pkg.sv
// vectrex_pkg: shared cartridge constants and loader state encoding
package vectrex_pkg;
  localparam int CART_AW = 15;
  localparam int CART_SIZE = 32768;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WAIT, ST_PULSE} state_t;
endpackage

// File: rtl/vectrex_mask_gen.sv
// vectrex_mask_gen: smallest all-ones mask covering an address
module vectrex_mask_gen
  import vectrex_pkg::*;
(
  input  logic [CART_AW-1:0] addr,
  output logic [CART_AW-1:0] mask
);
  logic [CART_AW-1:0] m1, m2, m4;
  assign m1 = addr | (addr >> 1);
  assign m2 = m1 | (m1 >> 2);
  assign m4 = m2 | (m2 >> 4);
  assign mask = m4 | (m4 >> 8);
endmodule

// File: rtl/vectrex_cart_loader.sv
// vectrex_cart_loader: write-through cartridge download with optional skip-logo reset pulse
module vectrex_cart_loader
  import vectrex_pkg::*;
#(
  parameter int TIMEOUT = 5000000,
  parameter int PULSE_LEN = 1000,
  parameter int MAX_ADDR_W = 15
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               ioctl_download,
  input  logic               ioctl_wr,
  input  logic [24:0]        ioctl_addr,
  input  logic [7:0]         ioctl_dout,
  input  logic               skip_logo,
  output logic               cart_wr,
  output logic [CART_AW-1:0] cart_addr,
  output logic [7:0]         cart_data,
  output logic [CART_AW-1:0] cart_mask,
  output logic               overflow,
  output logic               loaded,
  output logic               core_reset
);
  localparam logic [31:0] WAIT_LD = (TIMEOUT > PULSE_LEN) ? 32'(TIMEOUT - PULSE_LEN - 1) : 32'd0;
  localparam logic [31:0] PULSE_LD = (PULSE_LEN > 0) ? 32'(PULSE_LEN - 1) : 32'd0;
  state_t state, state_nx;
  logic dl_q, rise, fall, accept, in_range;
  logic [15:0] byte_cnt;
  logic [31:0] cnt;
  logic [CART_AW-1:0] addr_mask;
  assign rise = ioctl_download & ~dl_q;
  assign fall = ~ioctl_download & dl_q;
  assign accept = state == ST_LOAD && ioctl_download && ioctl_wr;
  assign in_range = (ioctl_addr >> MAX_ADDR_W) == 25'd0 && ioctl_addr < 25'(CART_SIZE);
  vectrex_mask_gen u_mask (.addr(ioctl_addr[CART_AW-1:0]), .mask(addr_mask));
  always_comb begin
    state_nx = state;
    if (rise) state_nx = ST_LOAD;
    else if (state == ST_LOAD && fall) state_nx = (skip_logo && byte_cnt != 16'd0) ? ST_WAIT : ST_IDLE;
    else if (state == ST_WAIT && cnt == 32'd0) state_nx = ST_PULSE;
    else if (state == ST_PULSE && cnt == 32'd0) state_nx = ST_IDLE;
  end
  always_ff @(posedge clk_sys)
    state <= reset ? ST_IDLE : state_nx;
  // dl_q tracks the live download level through reset so a download already high is never seen as a new start
  always_ff @(posedge clk_sys) begin
    dl_q <= ioctl_download;
    if (reset) begin
      cart_wr <= 1'b0;
      cart_addr <= '0;
      cart_data <= '0;
      cart_mask <= '0;
      overflow <= 1'b0;
      loaded <= 1'b0;
      core_reset <= 1'b0;
      byte_cnt <= '0;
      cnt <= '0;
    end else begin
      core_reset <= ioctl_download | (state_nx == ST_PULSE);
      cart_wr <= accept && in_range;
      if (accept && in_range) begin
        cart_addr <= ioctl_addr[CART_AW-1:0];
        cart_data <= ioctl_dout;
        cart_mask <= cart_mask | addr_mask;
        byte_cnt <= byte_cnt + 16'(byte_cnt != 16'hFFFF);
      end
      if (accept && !in_range) overflow <= 1'b1;
      if (state == ST_LOAD && fall) loaded <= byte_cnt != 16'd0;
      if (rise) begin
        cart_mask <= '0;
        overflow <= 1'b0;
        loaded <= 1'b0;
        byte_cnt <= '0;
      end
      cnt <= state == ST_LOAD ? WAIT_LD : (state == ST_WAIT && state_nx == ST_PULSE) ? PULSE_LD : cnt - 32'(cnt != 32'd0);
    end
  end
endmodule
